count_game_core: RTL and testbench

//  Parametrised round/score engine for the switch-count game. Each round it

---
 rtl/count_game_core.sv | 197 +++++++++++++++++++
 tb/tb_count_game_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_game_core.sv
// Round/score engine for the switch-count game: draws a target count each round,
// times the player's submission and tracks hits, rounds and the pass verdict.
module count_game_core #(
  parameter int unsigned SW_W       = 7,
  parameter int unsigned ROUNDS     = 3,
  parameter int unsigned TIME_LIMIT = 50_000_000,
  parameter int unsigned RESULT_CYC = 25_000_000,
  parameter int unsigned PASS_SCORE = 2,
  localparam int unsigned TW  = $clog2(SW_W + 1),
  localparam int unsigned CW  = $clog2(TIME_LIMIT + 1),
  localparam int unsigned RW  = $clog2(ROUNDS + 1),
  localparam int unsigned RCW = $clog2(RESULT_CYC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SW_W-1:0] sw,
  output logic [TW-1:0]   target,
  output logic [CW-1:0]   time_left,
  output logic [RW-1:0]   round_idx,
  output logic [RW-1:0]   score,
  output logic            hit,
  output logic            miss,
  output logic            beep,
  output logic            done,
  output logic            pass,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StPlay   = 3'd2,
    StResult = 3'd3,
    StDone   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    target_q, target_d;
  logic [CW-1:0]    time_left_q, time_left_d;
  logic [RW-1:0]    round_q, round_d;
  logic [RW-1:0]    score_q, score_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             beep_q, beep_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [RCW-1:0]   res_cnt_q, res_cnt_d;
  logic             start_q;
  logic [15:0]      lfsr_q;

  logic             sedge;
  logic [TW-1:0]    pop_cnt;
  logic             ok;
  logic [TW-1:0]    lfsr_lo;
  logic [TW-1:0]    lfsr_tgt;
  logic             tl_last;
  logic             res_last;
  logic [RW-1:0]    round_inc;

  assign sedge    = start & ~start_q;
  assign ok       = (pop_cnt == target_q);
  assign lfsr_lo  = lfsr_q[TW-1:0];
  assign lfsr_tgt = (lfsr_lo > TW'(SW_W)) ? TW'(SW_W) : lfsr_lo;
  assign tl_last  = (time_left_q == CW'(1));
  assign res_last = (res_cnt_q == RCW'(RESULT_CYC - 1));
  // Saturating so a finished game can never wrap round_idx back to zero.
  assign round_inc = (round_q == RW'(ROUNDS)) ? round_q : round_q + RW'(1);

  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < SW_W; i++) begin
      pop_cnt = pop_cnt + TW'(sw[i]);
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      target_q    <= '0;
      time_left_q <= '0;
      round_q     <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      beep_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      res_cnt_q   <= '0;
      start_q     <= 1'b0;
      lfsr_q      <= 16'hACE1;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      time_left_q <= time_left_d;
      round_q     <= round_d;
      score_q     <= score_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      beep_q      <= beep_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      res_cnt_q   <= res_cnt_d;
      start_q     <= start;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (sedge) state_d = StArm;
      StArm:    state_d = StPlay;
      StPlay:   if (sedge || tl_last) state_d = StResult;
      StResult: begin
        if (res_last) state_d = (round_inc == RW'(ROUNDS)) ? StDone : StArm;
      end
      StDone:   if (sedge) state_d = StArm;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    target_d    = target_q;
    time_left_d = time_left_q;
    round_d     = round_q;
    score_d     = score_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    beep_d      = beep_q;
    done_d      = done_q;
    pass_d      = pass_q;
    res_cnt_d   = res_cnt_q;
    case (state_q)
      StIdle: begin
        if (sedge) begin
          score_d = '0;
          round_d = '0;
        end
      end
      StArm: begin
        target_d    = lfsr_tgt;
        time_left_d = CW'(TIME_LIMIT);
      end
      StPlay: begin
        // A press on the last PLAY cycle still counts as a submission.
        if (sedge) begin
          hit_d     = ok;
          miss_d    = ~ok;
          beep_d    = ok;
          res_cnt_d = '0;
          if (ok && (score_q != RW'(ROUNDS))) score_d = score_q + RW'(1);
        end else if (tl_last) begin
          miss_d    = 1'b1;
          beep_d    = 1'b0;
          res_cnt_d = '0;
        end else begin
          time_left_d = time_left_q - CW'(1);
        end
      end
      StResult: begin
        if (res_last) begin
          beep_d  = 1'b0;
          round_d = round_inc;
          if (round_inc == RW'(ROUNDS)) begin
            done_d = 1'b1;
            pass_d = (score_q >= RW'(PASS_SCORE));
          end
        end else begin
          res_cnt_d = res_cnt_q + RCW'(1);
        end
      end
      StDone: begin
        if (sedge) begin
          score_d = '0;
          round_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign target    = target_q;
  assign time_left = time_left_q;
  assign round_idx = round_q;
  assign score     = score_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign beep      = beep_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign state     = state_q;

endmodule

// File: tb/tb_count_game_core.sv
// Directed bench for count_game_core: an LFSR model predicts targets and a
// scoreboard queue holds the expected outcome of each submission.
module tb_count_game_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] sw;
  logic [2:0] target;
  logic [6:0] time_left;
  logic [1:0] round_idx;
  logic [1:0] score;
  logic       hit, miss, beep, done, pass;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;

  typedef struct {
    logic       hit;
    logic       miss;
    logic [1:0] score;
    logic       beep;
  } exp_t;

  exp_t sb[$];
  int   tq[$];
  logic [15:0] m_lfsr;

  count_game_core #(
    .SW_W(7), .ROUNDS(3), .TIME_LIMIT(100), .RESULT_CYC(4), .PASS_SCORE(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sw(sw), .target(target),
    .time_left(time_left), .round_idx(round_idx), .score(score), .hit(hit),
    .miss(miss), .beep(beep), .done(done), .pass(pass), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ones(input int n);
    logic [6:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int clip(input logic [15:0] l);
    int v = int'(l[2:0]);
    return (v > 7) ? 7 : v;
  endfunction

  // Entered while ARM is observed. mode: 0 good press, 1 wrong press,
  // 2 timeout, 3 good press on the last PLAY cycle.
  task automatic do_round(input int mode, input int rounds_after);
    int   tgt, n;
    exp_t e;
    logic [6:0] tl_hold;
    tq.push_back(clip(m_lfsr));
    tick();
    chk("play_state", 32'(state), 2);
    tgt = tq.pop_front();
    chk("target", 32'(target), 32'(tgt));
    chk("time_left_init", 32'(time_left), 100);
    start = 1'b0;
    case (mode)
      0, 1: begin
        sw = ones((mode == 0) ? tgt : (tgt + 1) % 8);
        tick();
        chk("time_left_dec", 32'(time_left), 99);
        e = '{hit: (mode == 0), miss: (mode == 1),
              score: 2'(exp_score + ((mode == 0) ? 1 : 0)), beep: (mode == 0)};
        sb.push_back(e);
        start = 1'b1;
        tick();
      end
      2: begin
        sw = ones((tgt + 1) % 8);
        e = '{hit: 1'b0, miss: 1'b1, score: 2'(exp_score), beep: 1'b0};
        sb.push_back(e);
        n = 1;
        for (int i = 0; i < 200; i++) begin
          tick();
          if (state != 3'd2) break;
          n++;
        end
        chk("timeout_len", 32'(n), 100);
      end
      default: begin
        sw = ones(tgt);
        for (int i = 0; i < 200; i++) begin
          if (time_left == 7'd1) break;
          tick();
        end
        chk("reach_tl1", 32'(time_left), 1);
        e = '{hit: 1'b1, miss: 1'b0, score: 2'(exp_score + 1), beep: 1'b1};
        sb.push_back(e);
        start = 1'b1;
        tick();
      end
    endcase
    e = sb.pop_front();
    exp_score = int'(e.score);
    chk("result_state", 32'(state), 3);
    chk("hit", 32'(hit), 32'(e.hit));
    chk("miss", 32'(miss), 32'(e.miss));
    chk("score", 32'(score), 32'(e.score));
    chk("beep", 32'(beep), 32'(e.beep));
    tl_hold = time_left;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("result_hold", 32'(state), 3);
      chk("hit_pulse", 32'(hit | miss), 0);
      chk("beep_hold", 32'(beep), 32'(e.beep));
      chk("tl_frozen", 32'(time_left), 32'(tl_hold));
    end
    tick();
    chk("after_result", 32'(state), (rounds_after == 3) ? 4 : 1);
    chk("round_idx", 32'(round_idx), 32'(rounds_after));
    chk("beep_off", 32'(beep), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sw = '0;
    tick();
    start = 1'b1;
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_round", 32'(round_idx), 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'h0000ACE1);
    chk("rst_pulses", 32'({hit, miss, beep, done, pass}), 0);
    chk("rst_target", 32'(target), 0);
    chk("rst_time_left", 32'(time_left), 0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(state), 0);
    start = 1'b1;
    tick();
    chk("start_arm", 32'(state), 1);

    // Game A: hit, timeout, last-cycle hit -> pass
    do_round(0, 1);
    do_round(2, 2);
    do_round(3, 3);
    chk("done_a", 32'(done), 1);
    chk("pass_a", 32'(pass), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_start_stays", 32'(state), 4);
    end
    start = 1'b0;
    tick();
    chk("released_stays", 32'(state), 4);
    start = 1'b1;
    tick();
    chk("restart_arm", 32'(state), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_round", 32'(round_idx), 0);
    chk("restart_done", 32'({done, pass}), 0);
    exp_score = 0;

    // Game B: miss, miss, hit -> fail
    do_round(1, 1);
    do_round(1, 2);
    do_round(0, 3);
    chk("done_b", 32'(done), 1);
    chk("pass_b", 32'(pass), 0);
    chk("score_b", 32'(score), 1);

    // Game C: reset in PLAY with score 1
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("arm_c", 32'(state), 1);
    exp_score = 0;
    do_round(0, 1);
    tick();
    chk("play_c", 32'(state), 2);
    chk("score_c", 32'(score), 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk("midrst_state", 32'(state), 0);
    chk("midrst_score", 32'(score), 0);
    chk("midrst_round", 32'(round_idx), 0);
    tick();
    chk("midrst_hold", 32'(state), 0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(state), 0);
    start = 1'b1;
    tick();
    chk("post_rst_arm", 32'(state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
